// File: rtl/stack_host_ctrl.sv
// Initiator for a push/pop stack: shadow depth pre-checks, four-phase
// strobe/done handshake with timeout, and a registered response channel.
module stack_host_ctrl #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [DATA_W-1:0]            cmd_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_data,
  output logic [1:0]                   rsp_status,
  output logic                         stk_push,
  output logic                         stk_pop,
  output logic [DATA_W-1:0]            stk_wdata,
  input  logic [DATA_W-1:0]            stk_rdata,
  input  logic                         stk_done,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         busy
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_OVF = 2'b01;
  localparam logic [1:0] ST_UDF = 2'b10;
  localparam logic [1:0] ST_ERR = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, REL, RSP} state_t;

  state_t            state;
  logic [1:0]        op;
  logic              back;
  logic [DATA_W-1:0] dreg;
  logic [TW-1:0]     tcnt;

  logic tmo;
  logic bad_op;
  logic full;
  logic empty;
  logic go;

  assign cmd_ready = (state == IDLE) && stk_done;
  assign busy      = (state != IDLE);
  assign tmo       = (tcnt == TW'(TIMEOUT-1));
  assign bad_op    = (cmd_op == 2'b00);
  assign full      = (cmd_op == OP_PUSH) && (depth == DW'(DEPTH));
  assign empty     = cmd_op[1] && (depth == '0);
  assign go        = !(bad_op || full || empty);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op         <= 2'b00;
      back       <= 1'b0;
      dreg       <= '0;
      tcnt       <= '0;
      stk_push   <= 1'b0;
      stk_pop    <= 1'b0;
      stk_wdata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_status <= ST_OK;
      depth      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op   <= cmd_op;
            back <= 1'b0;
            tcnt <= '0;
            unique case (1'b1)
              bad_op: begin
                state      <= RSP;
                rsp_valid  <= 1'b1;
                rsp_status <= ST_ERR;
                rsp_data   <= '0;
              end
              full: begin
                state      <= RSP;
                rsp_valid  <= 1'b1;
                rsp_status <= ST_OVF;
                rsp_data   <= '0;
              end
              empty: begin
                state      <= RSP;
                rsp_valid  <= 1'b1;
                rsp_status <= ST_UDF;
                rsp_data   <= '0;
              end
              go: begin
                state <= REQ;
                if (cmd_op == OP_PUSH) begin
                  stk_push  <= 1'b1;
                  stk_wdata <= cmd_data;
                end else begin
                  stk_pop <= 1'b1;
                end
              end
            endcase
          end
        end
        REQ: begin
          if (!stk_done) begin
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
            tcnt     <= '0;
            state    <= REL;
          end else if (tmo) begin
            stk_push   <= 1'b0;
            stk_pop    <= 1'b0;
            state      <= RSP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_ERR;
            rsp_data   <= '0;
            if (back) depth <= depth - 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        REL: begin
          if (stk_done) begin
            unique case (1'b1)
              op == OP_PUSH: begin
                depth      <= depth + 1'b1;
                state      <= RSP;
                rsp_valid  <= 1'b1;
                rsp_status <= ST_OK;
                rsp_data   <= '0;
              end
              op == OP_POP: begin
                dreg       <= stk_rdata;
                depth      <= depth - 1'b1;
                state      <= RSP;
                rsp_valid  <= 1'b1;
                rsp_status <= ST_OK;
                rsp_data   <= stk_rdata;
              end
              op == OP_PEEK && !back: begin
                // restore the popped cell before answering
                dreg      <= stk_rdata;
                stk_wdata <= stk_rdata;
                stk_push  <= 1'b1;
                back      <= 1'b1;
                tcnt      <= '0;
                state     <= REQ;
              end
              default: begin
                state      <= RSP;
                rsp_valid  <= 1'b1;
                rsp_status <= ST_OK;
                rsp_data   <= dreg;
              end
            endcase
          end else if (tmo) begin
            state      <= RSP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_ERR;
            rsp_data   <= '0;
            if (back) depth <= depth - 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_host_ctrl.sv
// Bench for stack_host_ctrl: behavioural stack device plus a queue-based
// reference of the controller's visible results.
module tb_stack_host_ctrl;

  logic       clk = 0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_wdata;
  logic [7:0] stk_rdata;
  logic       stk_done;
  logic [4:0] depth;
  logic       busy;

  stack_host_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .stk_done(stk_done), .depth(depth), .busy(busy)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // stack device: done falls 2 cycles after a strobe, rises 2 cycles later
  logic [7:0] dev[$];
  bit         model_en = 1;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!model_en) continue;
      if (stk_push || stk_pop) begin
        bit         p;
        logic [7:0] w;
        p = stk_push;
        w = stk_wdata;
        repeat (2) @(posedge clk);
        #1;
        stk_done = 0;
        if (p) dev.push_back(w);
        else if (dev.size() > 0) stk_rdata = dev.pop_back();
        repeat (2) @(posedge clk);
        #1;
        stk_done = 1;
      end
    end
  end

  int         push_rises = 0, pop_rises = 0, push_hi = 0;
  int         viol = 0, rsp_seen = 0;
  logic [7:0] last_w;
  bit         pp = 0, pq = 0;

  always @(negedge clk) begin
    if (stk_push && stk_pop) viol++;
    if ((stk_push || stk_pop) && !busy) viol++;
    if (stk_push) push_hi++;
    if (stk_push && !pp) begin
      push_rises++;
      last_w = stk_wdata;
    end
    if (stk_pop && !pq) pop_rises++;
    if (rsp_valid) rsp_seen++;
    pp = stk_push;
    pq = stk_pop;
  end

  logic [7:0] refq[$];

  task automatic ref_cmd(input logic [1:0] op, input logic [7:0] d,
                         output logic [1:0] st, output logic [7:0] rd);
    st = 2'b00;
    rd = 8'h00;
    case (op)
      2'b01: if (refq.size() == 16) st = 2'b01; else refq.push_back(d);
      2'b10: if (refq.size() == 0) st = 2'b10; else rd = refq.pop_back();
      2'b11: if (refq.size() == 0) st = 2'b10; else rd = refq[$];
      default: st = 2'b11;
    endcase
  endtask

  logic [1:0] st;
  logic [7:0] rd;
  int         lat;
  bit         p0, q0, stable;
  logic [7:0] w0;

  task automatic send(input logic [1:0] op, input logic [7:0] d,
                      input int hold);
    int n;
    @(negedge clk);
    cmd_valid = 1;
    cmd_op    = op;
    cmd_data  = d;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 0, 1);
      cmd_valid = 0;
      st = 2'bxx;
      rd = 8'hxx;
      return;
    end
    @(negedge clk);
    cmd_valid = 0;
    p0 = stk_push;
    q0 = stk_pop;
    w0 = stk_wdata;
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 0, 1);
    st = rsp_status;
    rd = rsp_data;
    stable = 1;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== 1 || rsp_status !== st || rsp_data !== rd ||
          cmd_ready !== 0) stable = 0;
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic run(input string tag, input logic [1:0] op,
                     input logic [7:0] d, input int hold);
    logic [1:0] es;
    logic [7:0] ed;
    ref_cmd(op, d, es, ed);
    send(op, d, hold);
    check({tag, "_status"}, st, es);
    check({tag, "_data"}, rd, ed);
    check({tag, "_depth"}, depth, refq.size());
  endtask

  initial begin
    int         n, a, b;
    bit         ok;
    logic [1:0] rop;
    rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_data = 0;
    rsp_ready = 0; stk_done = 1; stk_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_push", stk_push, 0);
    check("rst_pop", stk_pop, 0);
    check("rst_wdata", stk_wdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_status", rsp_status, 0);
    check("rst_depth", depth, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1;

    run("push_a5", 2'b01, 8'hA5, 0);
    check("push_strobe_next", p0, 1);
    check("push_wdata", w0, 8'hA5);

    run("pop_a5", 2'b10, 8'h00, 0);
    check("pop_strobe_next", q0, 1);

    a = pop_rises;
    run("pop_empty", 2'b10, 8'h00, 0);
    check("pop_empty_lat", lat, 0);
    check("pop_empty_nostrobe", pop_rises - a, 0);

    model_en = 0;
    a = push_hi;
    send(2'b01, 8'h77, 0);
    check("tmo_status", st, 2'b11);
    check("tmo_data", rd, 0);
    check("tmo_depth", depth, 0);
    check("tmo_push_cycles", push_hi - a, 64);
    model_en = 1;

    a = push_rises;
    b = pop_rises;
    run("op00", 2'b00, 8'h12, 0);
    check("op00_lat", lat, 0);
    check("op00_nostrobe", (push_rises - a) + (pop_rises - b), 0);

    for (int i = 0; i < 16; i++) run("fill", 2'b01, 8'(i), 0);
    a = push_rises;
    run("push_full", 2'b01, 8'h55, 0);
    check("full_nostrobe", push_rises - a, 0);

    a = push_rises;
    b = pop_rises;
    run("peek_full", 2'b11, 8'h00, 0);
    check("peek_pops", pop_rises - b, 1);
    check("peek_pushes", push_rises - a, 1);
    check("peek_pushback", last_w, 8'h0F);

    run("pop_hold", 2'b10, 8'h00, 5);
    check("hold_stable", stable, 1);

    model_en = 0;
    @(negedge clk);
    stk_done = 0;
    cmd_valid = 1;
    cmd_op = 2'b01;
    ok = 1;
    repeat (5) begin
      @(negedge clk);
      if (cmd_ready !== 0 || busy !== 0) ok = 0;
    end
    check("done_low_no_accept", ok, 1);
    cmd_valid = 0;
    stk_done = 1;
    model_en = 1;

    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("reset2_depth", depth, 0);
    dev.delete();
    refq.delete();
    for (int i = 0; i < 3; i++) run("pre", 2'b01, 8'(8'hC0 + i), 0);

    @(negedge clk);
    cmd_valid = 1;
    cmd_op = 2'b10;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (stk_done && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    check("in_rel", {busy, stk_pop, stk_done}, 3'b100);
    rst_n = 0;
    @(negedge clk);
    check("rrel_push", stk_push, 0);
    check("rrel_pop", stk_pop, 0);
    check("rrel_depth", depth, 0);
    check("rrel_rsp_valid", rsp_valid, 0);
    check("rrel_busy", busy, 0);
    rst_n = 1;
    a = rsp_seen;
    repeat (10) @(negedge clk);
    check("rrel_no_rsp", rsp_seen - a, 0);
    n = 0;
    while (!stk_done && n < 20) begin @(negedge clk); n++; end
    dev.delete();
    refq.delete();

    for (int i = 0; i < 60; i++) begin
      rop = (i < 20) ? 2'b01 : 2'($urandom_range(0, 3));
      run("rand", rop, 8'($urandom), $urandom_range(0, 2));
    end

    check("strobe_rules", viol, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
